// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad: FSM states, tap indices,
// width defaults and a sign-extension helper macro.
`ifndef IIR_PKG_SV
`define IIR_PKG_SV

// Sign-extend a named signal from from_w bits to to_w bits (to_w > from_w).
`define IIR_SEXT(sig, from_w, to_w) {{((to_w)-(from_w)){sig[(from_w)-1]}}, sig}

package iir_pkg;

  localparam int N_DEF     = 24;
  localparam int F_DEF     = 15;
  localparam int GUARD_DEF = 3;
  localparam int TAP_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [TAP_W-1:0] TAP_B0  = 3'd0;
  localparam logic [TAP_W-1:0] TAP_B1  = 3'd1;
  localparam logic [TAP_W-1:0] TAP_B2  = 3'd2;
  localparam logic [TAP_W-1:0] TAP_NA1 = 3'd3;
  localparam logic [TAP_W-1:0] TAP_NA2 = 3'd4;

endpackage

`endif

// File: rtl/iir_tap_mux.sv
// Coefficient/operand selector for the biquad MAC: picks the pair for the
// current tap, zero for unused tap codes.
module iir_tap_mux
  import iir_pkg::*;
#(
  parameter int                N     = N_DEF,
  parameter logic signed [N-1:0] C_B0  = '0,
  parameter logic signed [N-1:0] C_B1  = '0,
  parameter logic signed [N-1:0] C_B2  = '0,
  parameter logic signed [N-1:0] C_NA1 = '0,
  parameter logic signed [N-1:0] C_NA2 = '0
) (
  input  logic [TAP_W-1:0]    tap_i,
  input  logic signed [N-1:0] uk_i,
  input  logic signed [N-1:0] u1_i,
  input  logic signed [N-1:0] u2_i,
  input  logic signed [N-1:0] y1_i,
  input  logic signed [N-1:0] y2_i,
  output logic signed [N-1:0] coef_o,
  output logic signed [N-1:0] oper_o
);

  always_comb begin
    coef_o = '0;
    oper_o = '0;
    case (tap_i)
      TAP_B0:  begin coef_o = C_B0;  oper_o = uk_i; end
      TAP_B1:  begin coef_o = C_B1;  oper_o = u1_i; end
      TAP_B2:  begin coef_o = C_B2;  oper_o = u2_i; end
      TAP_NA1: begin coef_o = C_NA1; oper_o = y1_i; end
      TAP_NA2: begin coef_o = C_NA2; oper_o = y2_i; end
      default: ;
    endcase
  end

endmodule

// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad with one shared multiplier stepped over five taps per sample.
// Define OPT_SAT_EN to clamp the output to the N-bit range instead of wrapping.
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int F     = F_DEF,
  parameter int B0    = 26646,
  parameter int B1    = 53280,
  parameter int B2    = 26646,
  parameter int NA1   = -52133,
  parameter int NA2   = -21682,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample_valid,
  input  logic signed [N-1:0] u_in,
  output logic                busy,
  output logic                y_valid,
  output logic signed [N-1:0] y_out,
  output logic                overrun
);

  localparam int PW = 2 * N;
  localparam int AW = PW + GUARD;

  localparam logic signed [N-1:0] C_B0  = N'(B0);
  localparam logic signed [N-1:0] C_B1  = N'(B1);
  localparam logic signed [N-1:0] C_B2  = N'(B2);
  localparam logic signed [N-1:0] C_NA1 = N'(NA1);
  localparam logic signed [N-1:0] C_NA2 = N'(NA2);

  state_e                state_q, state_d;
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [N-1:0]   uk_q, uk_d, u1_q, u1_d, u2_q, u2_d;
  logic signed [N-1:0]   y1_q, y1_d, y2_q, y2_d;
  logic signed [N-1:0]   y_out_q, y_out_d;
  logic                  y_valid_q, y_valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic signed [N-1:0]   coef, oper;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [N-1:0]   result;

`ifdef OPT_SAT_EN
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] fit_result(input logic signed [AW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[N-1:0];
    else if (v < SAT_LO) return SAT_LO[N-1:0];
    else                 return v[N-1:0];
  endfunction

  logic signed [AW-1:0] acc_shr;
  assign acc_shr = acc_q >>> F;
  assign result  = fit_result(acc_shr);
`else
  // Wrapping keeps only the N bits just above the fraction; floor comes for free.
  function automatic logic signed [N-1:0] fit_result(input logic signed [N-1:0] v);
    return v;
  endfunction

  assign result = fit_result(acc_q[F +: N]);
`endif

  iir_tap_mux #(
    .N    (N),
    .C_B0 (C_B0),
    .C_B1 (C_B1),
    .C_B2 (C_B2),
    .C_NA1(C_NA1),
    .C_NA2(C_NA2)
  ) u_tap_mux (
    .tap_i (tap_q),
    .uk_i  (uk_q),
    .u1_i  (u1_q),
    .u2_i  (u2_q),
    .y1_i  (y1_q),
    .y2_i  (y2_q),
    .coef_o(coef),
    .oper_o(oper)
  );

  assign prod     = $signed(`IIR_SEXT(coef, N, PW)) * $signed(`IIR_SEXT(oper, N, PW));
  assign prod_ext = `IIR_SEXT(prod, PW, AW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tap_q     <= '0;
      acc_q     <= '0;
      uk_q      <= '0;
      u1_q      <= '0;
      u2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      uk_q      <= uk_d;
      u1_q      <= u1_d;
      u2_q      <= u2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE: begin
        if (!clear && sample_valid) begin
          state_d = MAC;
          tap_d   = TAP_B0;
        end
      end
      MAC: begin
        if (tap_q == TAP_NA2) begin
          state_d = DONE;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    uk_d      = uk_q;
    u1_d      = u1_q;
    u2_d      = u2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y_out_d   = y_out_q;
    y_valid_d = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          u1_d      = '0;
          u2_d      = '0;
          y1_d      = '0;
          y2_d      = '0;
          overrun_d = 1'b0;
        end else if (sample_valid) begin
          uk_d  = u_in;
          acc_d = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        if (sample_valid) overrun_d = 1'b1;
      end
      DONE: begin
        // History takes the value actually presented on y_out.
        y_out_d   = result;
        y_valid_d = 1'b1;
        u2_d      = u1_q;
        u1_d      = uk_q;
        y2_d      = y1_q;
        y1_d      = result;
        if (sample_valid) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_d  = (state_d != IDLE);
  assign busy    = busy_q;
  assign y_valid = y_valid_q;
  assign y_out   = y_out_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Self-checking bench for iir_biquad_seq: vector table, hand-written corner
// sequences and a randomized stream against an arithmetic reference model.
module tb_iir_biquad_seq;

  localparam int     N    = 24;
  localparam int     F    = 15;
  localparam longint CB0  = 26646;
  localparam longint CB1  = 53280;
  localparam longint CB2  = 26646;
  localparam longint CNA1 = -52133;
  localparam longint CNA2 = -21682;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: default coefficients; 1: B0 = 8388607; 2: B0 = 32768 (1.0).
  logic                clear_a [3];
  logic                sv_a    [3];
  logic signed [N-1:0] u_a     [3];
  logic                busy_a  [3];
  logic                yv_a    [3];
  logic signed [N-1:0] y_a     [3];
  logic                ov_a    [3];

  iir_biquad_seq dut (
    .clk(clk), .reset(reset), .clear(clear_a[0]), .sample_valid(sv_a[0]), .u_in(u_a[0]),
    .busy(busy_a[0]), .y_valid(yv_a[0]), .y_out(y_a[0]), .overrun(ov_a[0])
  );
  iir_biquad_seq #(.B0(8388607)) dut_ovf (
    .clk(clk), .reset(reset), .clear(clear_a[1]), .sample_valid(sv_a[1]), .u_in(u_a[1]),
    .busy(busy_a[1]), .y_valid(yv_a[1]), .y_out(y_a[1]), .overrun(ov_a[1])
  );
  iir_biquad_seq #(.B0(32768)) dut_neg (
    .clk(clk), .reset(reset), .clear(clear_a[2]), .sample_valid(sv_a[2]), .u_in(u_a[2]),
    .busy(busy_a[2]), .y_valid(yv_a[2]), .y_out(y_a[2]), .overrun(ov_a[2])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference history for instance 0.
  longint mu1, mu2, my1, my2;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fitn(input longint r);
    longint lim, w;
    lim = longint'(1) <<< (N - 1);
`ifdef OPT_SAT_EN
    if (r > lim - 1) return lim - 1;
    if (r < -lim)    return -lim;
    return r;
`else
    w = r & ((longint'(1) <<< N) - 1);
    if (w >= lim) w = w - (longint'(1) <<< N);
    return w;
`endif
  endfunction

  function automatic longint model_y(input longint b0, input longint u0, input longint u1,
                                     input longint u2, input longint y1, input longint y2);
    longint acc;
    acc = b0 * u0 + CB1 * u1 + CB2 * u2 + CNA1 * y1 + CNA2 * y2;
    return fitn(acc >>> F);
  endfunction

  task automatic model_clear();
    mu1 = 0; mu2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic model_accept(input longint u, output longint y);
    y   = model_y(CB0, u, mu1, mu2, my1, my2);
    mu2 = mu1; mu1 = u;
    my2 = my1; my1 = y;
  endtask

  // Waits for y_valid, counting edges from the current point; lat=-1 on timeout.
  task automatic wait_y(input int inst, input int start, output int lat);
    lat = -1;
    for (int k = start; k <= 12; k++) begin
      @(posedge clk); #1;
      if (yv_a[inst]) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called #1 after an edge; the strobe is sampled at the following edge (e0).
  task automatic run_sample(input int inst, input longint u, output longint y, output int lat);
    sv_a[inst] = 1'b1;
    u_a[inst]  = N'(u);
    @(posedge clk); #1;
    sv_a[inst] = 1'b0;
    wait_y(inst, 1, lat);
    y = y_a[inst];
  endtask

  task automatic pulse_clear();
    clear_a[0] = 1'b1;
    @(posedge clk); #1;
    clear_a[0] = 1'b0;
    model_clear();
  endtask

  typedef struct {
    longint u;
    bit     use_const;
    longint y;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ym, yg, yhold;
    int     lat, spur;
    logic signed [N-1:0] rs;

    tbl[0] = '{u: 32768,  use_const: 1'b1, y: 26646};
    tbl[1] = '{u: 0,      use_const: 1'b1, y: 10886};
    tbl[2] = '{u: 0,      use_const: 1'b0, y: 0};
    tbl[3] = '{u: 0,      use_const: 1'b0, y: 0};
    tbl[4] = '{u: -32768, use_const: 1'b0, y: 0};
    tbl[5] = '{u: 12345,  use_const: 1'b0, y: 0};
    tbl[6] = '{u: -1,     use_const: 1'b0, y: 0};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clear_a[i] = 1'b0; sv_a[i] = 1'b0; u_a[i] = '0;
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a[0], 0);
    check("rst_yvalid", yv_a[0], 0);
    check("rst_yout", y_a[0], 0);
    check("rst_overrun", ov_a[0], 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Impulse and follow-on vectors, back to back at one sample per 7 clocks.
    for (int i = 0; i < 7; i++) begin
      model_accept(tbl[i].u, ym);
      run_sample(0, tbl[i].u, yg, lat);
      check("tbl_y", yg, tbl[i].use_const ? tbl[i].y : ym);
      check("tbl_lat", lat, 6);
    end

    // Busy/valid timing for a single isolated sample.
    @(posedge clk); #1;
    sv_a[0] = 1'b1; u_a[0] = 24'sd1000;
    model_accept(1000, ym);
    @(posedge clk); #1;
    sv_a[0] = 1'b0;
    check("busy_e0", busy_a[0], 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check("busy_ek", busy_a[0], (k < 6) ? 1 : 0);
      check("yvalid_ek", yv_a[0], (k == 6) ? 1 : 0);
    end
    check("single_y", y_a[0], ym);
    yhold = y_a[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_yvalid", yv_a[0], 0);
      check("hold_yout", y_a[0], yhold);
    end

    // Overrun: second strobe three clocks into the first computation.
    pulse_clear();
    check("clr_overrun", ov_a[0], 0);
    sv_a[0] = 1'b1; u_a[0] = 24'sd32768;
    model_accept(32768, ym);
    @(posedge clk); #1;
    sv_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sv_a[0] = 1'b1; u_a[0] = 24'sd5000;
    @(posedge clk); #1;
    sv_a[0] = 1'b0;
    wait_y(0, 4, lat);
    check("ovr_lat", lat, 6);
    check("ovr_y", y_a[0], 26646);
    check("ovr_flag", ov_a[0], 1);
    @(posedge clk); #1;
    pulse_clear();
    check("ovr_cleared", ov_a[0], 0);
    run_sample(0, 32768, yg, lat);
    model_accept(32768, ym);
    check("post_clr_y", yg, 26646);

    // Reset in the middle of the tap sequence.
    @(posedge clk); #1;
    sv_a[0] = 1'b1; u_a[0] = 24'sd32768;
    @(posedge clk); #1;
    sv_a[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy_a[0], 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy_a[0], 0);
    check("mid_rst_yout", y_a[0], 0);
    check("mid_rst_yvalid", yv_a[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    spur = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (yv_a[0]) spur++;
    end
    check("no_spurious", spur, 0);
    run_sample(0, 32768, yg, lat);
    model_accept(32768, ym);
    check("post_rst_y", yg, 26646);
    check("post_rst_lat", lat, 6);

    // Randomized stream with occasional flushes and idle gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_clear();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      rs = N'($urandom);
      if (i % 2 == 1) rs = rs >>> 6;
      model_accept(longint'(rs), ym);
      run_sample(0, longint'(rs), yg, lat);
      check("rand_y", yg, ym);
      check("rand_lat", lat, 6);
    end

    // Output range boundary and floor behaviour on the alternative instances.
    run_sample(1, 8388607, yg, lat);
`ifdef OPT_SAT_EN
    check("ovf_y", yg, 8388607);
`else
    check("ovf_y", yg, -512);
`endif
    run_sample(2, -1, yg, lat);
    check("neg_floor_y", yg, -1);
    check("neg_lat", lat, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_biquad_seq.md
Name: iir_biquad_seq

Overview:
- Time-multiplexed, parametrised direct-form-I biquad section for the fixed-point filter datapath.
- Generalises the operand/coefficient selection into a self-sequencing engine: one signed multiplier plus a wide accumulator.
- A tap counter steps the five products of each sample and keeps the u/y history registers internally.
- Sits between the sample source (ADC/timer strobe) and the output register/DAC path.

Parameters:
- N, 24, total signed data/coefficient width.
- F, 15, fractional bits (Q(N-F).F).
- B0, 26646, raw signed b0 coefficient (about 0.813).
- B1, 53280, raw signed b1 coefficient (about 1.626).
- B2, 26646, raw signed b2 coefficient.
- NA1, -52133, raw signed negated a1 coefficient (about -1.591), added in the sum.
- NA2, -21682, raw signed negated a2 coefficient (about -0.662), added in the sum.
- GUARD, 3, extra accumulator guard bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the history registers, sampled only in IDLE.
- sample_valid  in  1  one-cycle strobe; u_in is valid.
- u_in  in  N  signed input sample.
- busy  out  1  high while a sample is being processed.
- y_valid  out  1  one-cycle pulse; y_out is updated.
- y_out  out  N  signed filtered output, held between pulses.
- overrun  out  1  sticky flag: a sample_valid arrived while not IDLE; cleared by reset or clear.

Behaviour:
- Reset (async, active-high): state=IDLE, tap=0, acc=0, uk=u1=u2=y1=y2=0, y_out=0, y_valid=0, busy=0, overrun=0. Reset asserted mid-sequence aborts the sample; no y_valid is produced.
- Equation: y[n] = B0*u[n] + B1*u[n-1] + B2*u[n-2] + NA1*y[n-1] + NA2*y[n-2].
- Products are 2N-bit signed. The accumulator is 2N+GUARD bits signed with no intermediate rounding.
- Result = acc >>> F (arithmetic shift, truncation toward -inf), then the low N bits (wrap) unless OPT_SAT_EN.
- State IDLE:
  - clear=1: u1,u2,y1,y2,overrun <= 0; sample_valid is ignored in that cycle.
  - Otherwise, sample_valid=1: uk <= u_in, acc <= 0, tap <= 0, go to MAC.
- State MAC: each clock, acc <= acc + coef(tap)*oper(tap).
  - Tap order: 0 B0*uk, 1 B1*u1, 2 B2*u2, 3 NA1*y1, 4 NA2*y2.
  - tap increments; after tap 4, go to DONE.
- State DONE: y_out <= result, y_valid <= 1 for exactly one cycle; u2<=u1, u1<=uk, y2<=y1, y1<=result; go to IDLE.
- Timing, with sample_valid sampled at edge e0:
  - Accumulation on edges e1..e5.
  - y_out/y_valid registered at e6.
  - Latency is 6 clocks; the next sample is accepted at e7 at the earliest, so throughput is 1 sample per 7 clocks.
- busy = (state != IDLE), registered; high from after e0 until after e6.
- sample_valid while busy: the sample is dropped, overrun <= 1, and the in-flight computation is unaffected.
- The history always stores the post-wrap/saturate value actually output.

Optional Feature:
- Macro: OPT_SAT_EN.
- Defined: if the shifted result exceeds the N-bit range, clamp to +2^(N-1)-1 or -2^(N-1). History stores the clamped value.
- Undefined: two's-complement wrap to N bits; no comparator logic is synthesised.

Decomposition:
- Shared package/header iir_pkg (include file in this codebase): state encodings IDLE/MAC/DONE, tap index constants TAP_B0..TAP_NA2, N/F defaults, sign-extension helper macro.
- Sub-module iir_tap_mux: combinational selection of coefficient and operand from tap (5-way, default 0).
- Top module: FSM, counter, MAC, history and handshake.

Test Plan:
- Impulse, defaults: u_in=32768 then zeros, one sample per 7 clocks -> first y_out=26646, second y_out=10886; y_valid exactly 6 clocks after each sample_valid.
- Latency/busy: a single sample -> busy high for cycles 1..6 after the strobe, y_valid high only in cycle 6, y_out held afterwards.
- Overrun: second sample_valid 3 clocks after the first -> overrun=1, and the first result matches the single-sample result exactly; clear in IDLE -> overrun=0 and history zeroed (next impulse reproduces 26646).
- Reset mid-MAC: assert reset at tap 2 -> all outputs 0 immediately; after release, an impulse gives 26646 again, with no spurious y_valid.
- Overflow: B0=8388607 override, u_in=8388607 -> with OPT_SAT_EN y_out=8388607; without it, y_out equals the low 24 bits of (8388607*8388607)>>>15.
- Negative rounding: B0=32768 (1.0), u_in=-1 -> y_out=-1 (floor, not toward zero).
